// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, reset PC and the fetch-queue entry layout.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  localparam logic [CPU_ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  // Queue entries are packed as {pc, inst}, PC in the upper bits.
  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bundle: PC-unit side, instruction-memory handshake and decode side.
interface inst_fetch_queue_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  logic              pc_ce;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_stall;
  logic              flush;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;

  // master is the fetch queue itself; slave is the surrounding PC unit, memory and decode.
  modport master (
    input  pc_ce, pc_addr, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    output pc_stall, inst_req, inst_addr, id_valid, id_inst, id_pc
  );

  modport slave (
    output pc_ce, pc_addr, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    input  pc_stall, inst_req, inst_addr, id_valid, id_inst, id_pc
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with active-low reset and an extra synchronous clear.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues PC-ordered memory requests, tags responses with their PC and
// queues {pc, inst} for decode; a flush drops the queue and discards in-flight data.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);
  localparam int SW  = $clog2(DEPTH + MAX_OUT + 1);
  localparam int EW  = ADDR_W + DATA_W;

  logic [QCW-1:0]    q_cnt;
  logic [OCW-1:0]    out_cnt;
  logic [OCW-1:0]    disc_cnt;
  logic [SW-1:0]     inflight;
  logic              tag_full, tag_empty, q_full, q_empty;
  logic [ADDR_W-1:0] tag_head;
  logic [EW-1:0]     q_head;
  logic              credit, req, accept, rsp, drop, enq, deq;

  // Every queue slot already promised to an outstanding response counts against space.
  assign inflight = SW'(q_cnt) + SW'(out_cnt);
  assign credit   = ~tag_full & ~q_full & (inflight < SW'(DEPTH));
  assign req      = bus.pc_ce & credit & ~bus.flush & rst;
  assign accept   = req & bus.inst_addr_ok;
  assign rsp      = bus.inst_data_ok & ~tag_empty;
  assign drop     = bus.flush | (disc_cnt != '0);
  assign enq      = rsp & ~drop;
  assign deq      = ~q_empty & bus.id_ready & ~bus.flush;

  assign bus.inst_req  = req;
  assign bus.inst_addr = bus.pc_addr;
  assign bus.pc_stall  = bus.pc_ce & ~accept & rst;
  assign bus.id_valid  = ~q_empty;
  assign bus.id_pc     = q_empty ? ADDR_W'(RESET_PC) : q_head[EW-1:DATA_W];
  assign bus.id_inst   = q_empty ? '0 : q_head[DATA_W-1:0];

  // Responses already in flight at a flush belong to the old path and arrive first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disc_cnt <= '0;
    end else if (bus.flush) begin
      disc_cnt <= out_cnt - OCW'(rsp);
    end else if (rsp && (disc_cnt != '0)) begin
      disc_cnt <= disc_cnt - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (accept),
    .pop   (rsp),
    .din   (bus.pc_addr),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (out_cnt)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .push  (enq),
    .pop   (deq),
    .din   ({tag_head, bus.inst_rdata}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Cycle-table bench for inst_fetch_queue with a PC-unit/memory model and a {pc, inst} scoreboard.
module tb_inst_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] INST_KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_queue #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One record per clock: stimulus, memory/decode behaviour and expected handshake outputs.
  typedef struct {
    logic rs, ce, aok, rsp, rdy, fl;
    logic [31:0] tgt;
    logic er, es, ev;
    logic chk_a;
    logic [31:0] ea;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    int          ep;
  } mem_ent_t;

  vec_t         vt[$];
  mem_ent_t     mem_q[$];
  fetch_entry_t exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           epoch  = 0;
  int           cyc    = 0;
  logic [31:0]  pc_model = '0;
  logic         prev_rs = 1'b0;

  function automatic vec_t mk(input logic rs, ce, aok, rsp, rdy, fl, input logic [31:0] tgt,
                              input logic er, es, ev, input logic chk_a = 1'b0,
                              input logic [31:0] ea = 32'h0);
    vec_t v;
    v.rs = rs; v.ce = ce; v.aok = aok; v.rsp = rsp; v.rdy = rdy; v.fl = fl; v.tgt = tgt;
    v.er = er; v.es = es; v.ev = ev; v.chk_a = chk_a; v.ea = ea;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL c%0d %s: got %b, expected %b", cyc, name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL c%0d %s: got %h, expected %h", cyc, name, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input vec_t v);
    mem_ent_t     ent;
    fetch_entry_t e;
    logic         have;
    have             = 1'b0;
    ent              = '{pc: 32'h0, ep: 0};
    rst              = ~v.rs;
    bus.pc_ce        = v.ce;
    bus.pc_addr      = pc_model;
    bus.flush        = v.fl;
    bus.inst_addr_ok = v.aok;
    bus.id_ready     = v.rdy;
    bus.inst_data_ok = v.rsp;
    if (v.rsp && mem_q.size() > 0) begin
      ent  = mem_q[0];
      have = 1'b1;
      bus.inst_rdata = (ent.ep == epoch) ? (ent.pc ^ INST_KEY)
                                         : (32'hDEAD_0000 | {16'h0, ent.pc[15:0]});
    end else begin
      bus.inst_rdata = 32'hBAD0_0000;
    end

    @(negedge clk);
    check1("inst_req", bus.inst_req, v.er);
    check1("pc_stall", bus.pc_stall, v.es);
    check1("id_valid", bus.id_valid, v.ev);
    if (v.chk_a) check32("inst_addr", bus.inst_addr, v.ea);
    if (prev_rs && !v.rs) begin
      check32("id_pc_after_reset", bus.id_pc, 32'h0);
      check32("id_inst_after_reset", bus.id_inst, 32'h0);
    end
    if (!v.rs && !v.fl && bus.id_valid && v.rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c%0d unexpected_pop: got pc %h, expected no entry", cyc, bus.id_pc);
      end else begin
        e = exp_q.pop_front();
        check32("id_pc", bus.id_pc, e.pc);
        check32("id_inst", bus.id_inst, e.inst);
      end
    end

    if (have) begin
      mem_q.delete(0);
      if (!v.rs && !v.fl && ent.ep == epoch)
        exp_q.push_back('{pc: ent.pc, inst: ent.pc ^ INST_KEY});
    end
    if (v.rs) begin
      mem_q.delete();
      exp_q.delete();
      epoch++;
      pc_model = 32'h0;
    end else begin
      if (v.fl) begin
        exp_q.delete();
        epoch++;
      end
      if (bus.inst_req && v.aok) mem_q.push_back('{pc: pc_model, ep: epoch});
      if (v.fl) pc_model = v.tgt;
      else if (v.ce && !bus.pc_stall) pc_model = pc_model + 32'd4;
    end
    prev_rs = v.rs;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b0;
    bus.pc_ce        = 1'b0;
    bus.pc_addr      = '0;
    bus.flush        = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.id_ready     = 1'b0;

    // Reset, then free-running stream with single-cycle memory.
    repeat (2) vt.push_back(mk(1,1,1,1,1,0,0, 0,0,0));
    repeat (2) vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0));
    repeat (6) vt.push_back(mk(0,1,1,1,1,0,0, 1,0,1));
    // Decode back-pressure: four entries, then the PC is held at 0x10.
    vt.push_back(mk(1,1,1,1,0,0,0, 0,0,1));
    repeat (2) vt.push_back(mk(0,1,1,1,0,0,0, 1,0,0));
    repeat (2) vt.push_back(mk(0,1,1,1,0,0,0, 1,0,1));
    repeat (3) vt.push_back(mk(0,1,1,1,0,0,0, 0,1,1, 1, 32'h10));
    vt.push_back(mk(0,1,1,1,1,0,0, 0,1,1, 1, 32'h10));
    repeat (4) vt.push_back(mk(0,1,1,1,1,0,0, 1,0,1));
    // Memory refuses 0x20 for five cycles.
    repeat (3) vt.push_back(mk(0,1,0,1,1,0,0, 1,1,1, 1, 32'h20));
    repeat (2) vt.push_back(mk(0,1,0,1,1,0,0, 1,1,0, 1, 32'h20));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h20));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h24));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,1));
    // Flush to 0x100 with two responses outstanding and two entries queued.
    vt.push_back(mk(1,1,1,1,0,0,0, 0,0,1));
    repeat (2) vt.push_back(mk(0,1,1,1,0,0,0, 1,0,0));
    vt.push_back(mk(0,1,1,1,0,0,0, 1,0,1));
    vt.push_back(mk(0,1,1,0,0,0,0, 1,0,1));
    vt.push_back(mk(0,1,1,0,0,1,32'h100, 0,1,1));
    vt.push_back(mk(0,1,1,1,1,0,0, 0,1,0, 1, 32'h100));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h100));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h104));
    repeat (2) vt.push_back(mk(0,1,1,1,1,0,0, 1,0,1));
    // Flush to 0x200 coinciding with a response and id_ready.
    vt.push_back(mk(0,1,1,1,1,1,32'h200, 0,1,1));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h200));
    vt.push_back(mk(0,1,1,1,1,0,0, 1,0,0));
    repeat (2) vt.push_back(mk(0,1,1,1,1,0,0, 1,0,1));

    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++) run_cycle(vt[i]);

    // Reset mid-stream with two queued and one outstanding, then stray data_ok.
    run_cycle(mk(0,1,1,1,0,0,0, 1,0,1));
    run_cycle(mk(1,1,1,0,0,0,0, 0,0,1));
    repeat (3) run_cycle(mk(0,0,1,1,1,0,0, 0,0,0));
    run_cycle(mk(0,1,1,1,1,0,0, 1,0,0, 1, 32'h0));
    run_cycle(mk(0,1,1,1,1,0,0, 1,0,0));
    repeat (2) run_cycle(mk(0,1,1,1,1,0,0, 1,0,1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
